// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 host-side streaming initiator.
package sha256_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_WAIT    = 2'd2,
      ST_COLLECT = 2'd3
   } state_e;

   localparam int DIGEST_BYTES     = 32;
   localparam int BLOCK_BYTES      = 64;
   localparam int MAX_SINGLE_BLOCK = 55;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_SHORT   = 2'b11;

endpackage

// File: rtl/sha256_msg_buf.sv
// 64x8 message buffer: one synchronous write port, one asynchronous read port.
module sha256_msg_buf
   import sha256_pkg::*;
(
   input  logic       clk,
   input  logic       we_i,
   input  logic [5:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [5:0] raddr_i,
   output logic [7:0] rdata_o
);

   logic [7:0] mem_q [BLOCK_BYTES];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sha256_stream_host.sv
// Host initiator: streams a buffered single-block message to the SHA-256 core
// byte by byte, then collects the 32-byte digest burst it returns.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | buffer writable, waiting for start
// ST_SEND    | tx_valid high, one message byte per cycle
// ST_WAIT    | message sent, timing out the core's first digest byte
// ST_COLLECT | shifting digest bytes in until 32 received or frame breaks
module sha256_stream_host
   import sha256_pkg::*;
#(
   parameter int MAX_LEN = MAX_SINGLE_BLOCK,
   parameter int TIMEOUT = 1023
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [5:0]   wr_addr,
   input  logic [7:0]   wr_data,
   input  logic         start,
   input  logic [6:0]   msg_len,
   output logic [7:0]   tx_data,
   output logic         tx_valid,
   input  logic [7:0]   rx_data,
   input  logic         rx_valid,
   output logic         busy,
   output logic         done,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         err,
   output logic [1:0]   err_code
);

   localparam int TIMER_W = $clog2(TIMEOUT + 1);

   state_e               state_q;
   logic [5:0]           idx_q;
   logic [5:0]           len_q;
   logic [5:0]           cnt_q;
   logic [TIMER_W-1:0]   timer_q;
   logic [TIMER_W-1:0]   timer_d;
   logic [7:0]           tx_data_q;
   logic                 tx_valid_q;
   logic                 busy_q;
   logic                 done_q;
   logic [255:0]         digest_q;
   logic                 digest_valid_q;
   logic                 err_q;
   logic [1:0]           err_code_q;

   logic                 buf_we;
   logic [5:0]           buf_raddr;
   logic [7:0]           buf_rdata;
   logic [7:0]           first_byte;

   assign buf_we    = wr_en && (state_q == ST_IDLE);
   assign buf_raddr = (state_q == ST_SEND) ? idx_q : 6'd0;
   assign timer_d   = timer_q + TIMER_W'(1);

   // Byte 0 is loaded on the start edge, so a same-cycle write to it must bypass the buffer.
   assign first_byte = (wr_en && (wr_addr == 6'd0)) ? wr_data : buf_rdata;

   sha256_msg_buf u_buf (
      .clk     (clk),
      .we_i    (buf_we),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (buf_raddr),
      .rdata_o (buf_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         idx_q          <= '0;
         len_q          <= '0;
         cnt_q          <= '0;
         timer_q        <= '0;
         tx_data_q      <= '0;
         tx_valid_q     <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         err_q          <= 1'b0;
         err_code_q     <= ERR_NONE;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (msg_len == 7'd0 || msg_len > 7'(MAX_LEN)) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_LEN;
                  end else begin
                     // idx_q tracks the next byte to load; byte 0 goes out now
                     len_q          <= msg_len[5:0];
                     idx_q          <= 6'd1;
                     tx_data_q      <= first_byte;
                     tx_valid_q     <= 1'b1;
                     digest_valid_q <= 1'b0;
                     err_code_q     <= ERR_NONE;
                     busy_q         <= 1'b1;
                     state_q        <= ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (idx_q == len_q) begin
                  tx_valid_q <= 1'b0;
                  tx_data_q  <= '0;
                  timer_q    <= '0;
                  state_q    <= ST_WAIT;
               end else begin
                  tx_data_q <= buf_rdata;
                  idx_q     <= idx_q + 6'd1;
               end
            end
            ST_WAIT: begin
               timer_q <= timer_d;
               if (rx_valid) begin
                  digest_q <= {digest_q[247:0], rx_data};
                  cnt_q    <= 6'd1;
                  state_q  <= ST_COLLECT;
               end else if (timer_d == TIMER_W'(TIMEOUT)) begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_TIMEOUT;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            ST_COLLECT: begin
               if (rx_valid) begin
                  digest_q <= {digest_q[247:0], rx_data};
                  cnt_q    <= cnt_q + 6'd1;
                  if (cnt_q == 6'(DIGEST_BYTES - 1)) begin
                     done_q         <= 1'b1;
                     digest_valid_q <= 1'b1;
                     busy_q         <= 1'b0;
                     state_q        <= ST_IDLE;
                  end
               end else begin
                  err_q      <= 1'b1;
                  err_code_q <= ERR_SHORT;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign err          = err_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_sha256_stream_host.sv
// Directed self-checking bench for sha256_stream_host with a byte-level core model
// and queue scoreboards for streamed message bytes and returned digests.
module tb_sha256_stream_host;

   localparam int TIMEOUT = 1023;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         wr_en;
   logic [5:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         start;
   logic [6:0]   msg_len;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         busy;
   logic         done;
   logic [255:0] digest;
   logic         digest_valid;
   logic         err;
   logic [1:0]   err_code;

   sha256_stream_host #(.MAX_LEN(55), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .start        (start),
      .msg_len      (msg_len),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .busy         (busy),
      .done         (done),
      .digest       (digest),
      .digest_valid (digest_valid),
      .err          (err),
      .err_code     (err_code)
   );

   always #5 clk = ~clk;

   int           n_assert = 0;
   int           n_fail   = 0;
   logic [7:0]   msg [64];
   logic [255:0] reply_word;
   logic [7:0]   txq [$];
   logic [255:0] dgq [$];
   logic [255:0] abc_dig;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic write_msg(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         wr_en = 1'b1; wr_addr = 6'(i); wr_data = msg[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic expect_tx(input int n);
      for (int i = 0; i < n; i++) txq.push_back(msg[i]);
   endtask

   task automatic pulse_start(input int len);
      start = 1'b1; msg_len = 7'(len);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic rand_reply();
      for (int i = 0; i < 8; i++) reply_word = {reply_word[223:0], 32'($urandom())};
   endtask

   // Streams out tx bytes against the scoreboard; optional noise on ignored inputs.
   task automatic collect_tx(input int stop_after, input bit noise, output int cnt);
      logic [7:0] e;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         if (tx_valid) begin
            e = 'x;
            if (txq.size() > 0) e = txq.pop_front();
            check("tx_data", 256'(tx_data), 256'(e));
            check("busy_send", 256'(busy), 256'(1));
            cnt++;
            if (cnt == stop_after) break;
            if (noise) begin
               start = 1'b1; msg_len = 7'd5;
               wr_en = 1'b1; wr_addr = 6'(cnt + 1); wr_data = 8'hEE;
               rx_valid = 1'b1; rx_data = 8'h5A;
            end
         end else if (cnt > 0) begin
            break;
         end
         @(negedge clk);
      end
      start = 1'b0; wr_en = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic core_reply(input int n, input bit noise);
      if (n == 32) dgq.push_back(reply_word);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1; rx_data = reply_word[255 - 8*i -: 8];
         if (noise) begin
            start = 1'b1; msg_len = 7'd3;
            wr_en = 1'b1; wr_addr = 6'(i % 8); wr_data = 8'hC3;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0; start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic check_done();
      logic [255:0] e;
      e = 'x;
      if (dgq.size() > 0) e = dgq.pop_front();
      check("done", 256'(done), 256'(1));
      check("digest", digest, e);
      check("digest_valid", 256'(digest_valid), 256'(1));
      check("busy_idle", 256'(busy), 256'(0));
      check("err_quiet", 256'(err), 256'(0));
   endtask

   initial begin
      int cnt;
      int k;
      abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
      reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; msg_len = '0; rx_data = '0; rx_valid = 1'b0;
      @(negedge clk);
      check("rst_tx_valid", 256'(tx_valid), 256'(0));
      check("rst_tx_data", 256'(tx_data), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_done", 256'(done), 256'(0));
      check("rst_err", 256'(err), 256'(0));
      check("rst_err_code", 256'(err_code), 256'(0));
      check("rst_digest", digest, 256'(0));
      check("rst_digest_valid", 256'(digest_valid), 256'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // "abc"
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      write_msg(0, 3);
      expect_tx(3);
      pulse_start(3);
      collect_tx(0, 1'b0, cnt);
      check("abc_tx_count", 256'(cnt), 256'(3));
      reply_word = abc_dig;
      core_reply(32, 1'b0);
      check_done();
      check("abc_digest_const", digest, abc_dig);
      @(negedge clk);
      check("done_pulse_width", 256'(done), 256'(0));
      check("digest_valid_held", 256'(digest_valid), 256'(1));

      // illegal lengths 0 and 56
      pulse_start(0);
      check("len0_err", 256'(err), 256'(1));
      check("len0_code", 256'(err_code), 256'(1));
      check("len0_busy", 256'(busy), 256'(0));
      check("len0_tx_valid", 256'(tx_valid), 256'(0));
      @(negedge clk);
      check("len0_err_pulse", 256'(err), 256'(0));
      check("len0_code_held", 256'(err_code), 256'(1));
      pulse_start(56);
      check("len56_err", 256'(err), 256'(1));
      check("len56_code", 256'(err_code), 256'(1));
      check("len56_busy", 256'(busy), 256'(0));
      check("len56_tx_valid", 256'(tx_valid), 256'(0));
      check("len56_dv_kept", 256'(digest_valid), 256'(1));
      @(negedge clk);

      // maximum length 55
      for (int i = 0; i < 55; i++) msg[i] = 8'($urandom());
      write_msg(0, 55);
      expect_tx(55);
      pulse_start(55);
      check("len55_dv_cleared", 256'(digest_valid), 256'(0));
      check("len55_code_cleared", 256'(err_code), 256'(0));
      collect_tx(0, 1'b0, cnt);
      check("len55_tx_count", 256'(cnt), 256'(55));
      repeat (5) @(negedge clk);
      rand_reply();
      core_reply(32, 1'b0);
      check_done();
      @(negedge clk);

      // timeout: no reply
      expect_tx(1);
      pulse_start(1);
      collect_tx(0, 1'b0, cnt);
      check("to_tx_count", 256'(cnt), 256'(1));
      k = 0;
      while (!err && k < TIMEOUT + 20) begin
         @(negedge clk);
         k++;
      end
      check("to_latency", 256'(k), 256'(TIMEOUT));
      check("to_code", 256'(err_code), 256'(2));
      check("to_busy", 256'(busy), 256'(0));
      check("to_dv", 256'(digest_valid), 256'(0));
      @(negedge clk);
      check("to_err_pulse", 256'(err), 256'(0));

      // short frame: 20 bytes then rx_valid drops
      expect_tx(4);
      pulse_start(4);
      collect_tx(0, 1'b0, cnt);
      check("sf_tx_count", 256'(cnt), 256'(4));
      rand_reply();
      core_reply(20, 1'b0);
      check("sf_no_err_yet", 256'(err), 256'(0));
      check("sf_busy", 256'(busy), 256'(1));
      @(negedge clk);
      check("sf_err", 256'(err), 256'(1));
      check("sf_code", 256'(err_code), 256'(3));
      check("sf_done", 256'(done), 256'(0));
      check("sf_dv", 256'(digest_valid), 256'(0));
      check("sf_busy_idle", 256'(busy), 256'(0));
      @(negedge clk);

      // reset during SEND at byte 10 of 40
      for (int i = 0; i < 40; i++) msg[i] = 8'($urandom());
      write_msg(0, 40);
      expect_tx(40);
      pulse_start(40);
      collect_tx(10, 1'b0, cnt);
      check("rs_bytes_before", 256'(cnt), 256'(10));
      reset_n = 1'b0;
      #1;
      check("rs_tx_valid", 256'(tx_valid), 256'(0));
      check("rs_tx_data", 256'(tx_data), 256'(0));
      check("rs_busy", 256'(busy), 256'(0));
      check("rs_err_code", 256'(err_code), 256'(0));
      check("rs_digest", digest, 256'(0));
      txq.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // "abc" again, byte 0 written in the same cycle as start
      msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
      write_msg(1, 2);
      expect_tx(3);
      wr_en = 1'b1; wr_addr = 6'd0; wr_data = 8'h61;
      pulse_start(3);
      wr_en = 1'b0;
      collect_tx(0, 1'b0, cnt);
      check("abc2_tx_count", 256'(cnt), 256'(3));
      reply_word = abc_dig;
      core_reply(32, 1'b0);
      check_done();
      @(negedge clk);

      // ignored inputs during SEND and COLLECT, then back-to-back start
      for (int i = 0; i < 8; i++) msg[i] = 8'($urandom());
      write_msg(0, 8);
      expect_tx(8);
      pulse_start(8);
      collect_tx(0, 1'b1, cnt);
      check("nz_tx_count", 256'(cnt), 256'(8));
      rand_reply();
      core_reply(32, 1'b1);
      check_done();
      expect_tx(8);
      pulse_start(8);
      check("b2b_busy", 256'(busy), 256'(1));
      check("b2b_dv_cleared", 256'(digest_valid), 256'(0));
      collect_tx(0, 1'b0, cnt);
      check("b2b_tx_count", 256'(cnt), 256'(8));
      rand_reply();
      core_reply(32, 1'b0);
      check_done();
      check("scoreboard_tx_empty", 256'(txq.size()), 256'(0));
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_stream_host.md
Name: sha256_stream_host

Overview:
Host-side initiator for the byte-serial SHA-256 core interface. Holds a single-block message (1..55 bytes) in a local buffer and streams it to the core as contiguous valid-qualified bytes. Then waits for the core's digest burst and assembles the 32 returned bytes into a 256-bit digest. Sits between a control/register front end and the hashing core, driving the core's byte input and valid strobe and receiving the core's byte output and valid strobe.

Parameters:
MAX_LEN, 55, largest accepted message length in bytes (single-block limit)
TIMEOUT, 1023, max cycles in WAIT before aborting; also sets timer width (clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe; honoured only in IDLE
wr_addr  in  6  buffer byte address 0..63
wr_data  in  8  buffer byte
start  in  1  begin transaction; honoured only in IDLE
msg_len  in  7  message length in bytes, sampled with start
tx_data  out  8  byte to core
tx_valid  out  1  tx_data valid; high for exactly msg_len consecutive cycles
rx_data  in  8  digest byte from core
rx_valid  in  1  rx_data valid; core holds it high for 32 consecutive cycles, MSB byte first
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when 32 digest bytes have been captured
digest  out  256  assembled digest; first received byte in [255:248]
digest_valid  out  1  high from done until next accepted start or reset
err  out  1  one-cycle error pulse
err_code  out  2  01 bad length, 10 timeout, 11 short frame; held until next accepted start

Behaviour:
- Reset (async, reset_n low): state IDLE; tx_data=0, tx_valid=0, busy=0, done=0, err=0, err_code=0, digest=0, digest_valid=0, all counters and timer 0. Buffer contents need not be reset. Reset mid-transfer aborts immediately; tx_valid drops asynchronously.
- All outputs registered.
- States: IDLE, SEND, WAIT, COLLECT.
- IDLE: wr_en writes buf[wr_addr]<=wr_data. On start:
  - msg_len==0 or msg_len>MAX_LEN: err pulse, err_code=01, stay IDLE.
  - Otherwise: latch length, idx=0, clear digest_valid and err_code, go SEND.
  - start and wr_en in the same cycle: the write takes effect and start is accepted; the written byte is sent if within length.
- SEND: tx_valid=1, tx_data=buf[idx] on each cycle. If start is sampled at edge N, tx_valid is high for cycles N+1..N+len with no gaps. After the last byte, tx_valid=0, tx_data=0, timer=0, go WAIT.
- WAIT: timer increments each cycle.
  - rx_valid=1: capture the byte, cnt=1, go COLLECT.
  - timer reaches TIMEOUT with no rx_valid: err pulse, err_code=10, go IDLE.
- COLLECT: each rx_valid cycle does digest<={digest[247:0],rx_data}, cnt++.
  - On the 32nd byte: done pulse, digest_valid=1, go IDLE. Bytes beyond 32 are ignored while in IDLE.
  - rx_valid low before 32 bytes: err pulse, err_code=11, digest_valid stays 0, go IDLE.
- rx_valid in IDLE or SEND is ignored. start and wr_en outside IDLE are ignored; the buffer is stable during a transfer.
- Back-to-back: a start in the cycle after done is accepted normally.
- Widths: byte index 6 bits, receive count 6 bits (0..32), no wrap possible within legal limits.

Decomposition:
- Shared package sha256_pkg: state enum (IDLE/SEND/WAIT/COLLECT), DIGEST_BYTES=32, BLOCK_BYTES=64, MAX_SINGLE_BLOCK=55, err_code localparams.
- One sub-module, sha256_msg_buf: 64x8 register file, one write port, one async read port; no reset.
- FSM, timer and digest shifter stay in the top.

Test Plan:
- "abc" (61 62 63), len=3; bench core model replies with 32 bytes ba7816bf...f20015ad -> tx_valid high 3 cycles with 61,62,63; done pulse; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; digest_valid=1.
- Length checks: start with len=0, then len=56 -> err pulse each, err_code=01, busy never asserts, tx_valid stays 0. Then len=55 -> exactly 55 tx_valid cycles.
- Timeout: len=1, model never replies -> err pulse exactly TIMEOUT cycles after entering WAIT, err_code=10, back to IDLE.
- Short frame: model sends 20 valid bytes then drops rx_valid -> err_code=11, done never pulses, digest_valid=0.
- Reset mid-SEND: len=40, reset_n low at byte 10 -> tx_valid=0 immediately, all outputs at reset values. After release, a new "abc" transaction completes correctly.
- Ignored inputs: start and wr_en pulsed during SEND/COLLECT, rx_valid during SEND -> no effect on the streamed bytes or digest; back-to-back start right after done is accepted.
